// File: rtl/mbssoc_int_req.sv
// mbssoc_int_req: per-source interrupt requester with event queueing,
// ack handshake, re-arm on timeout and sticky overflow flags.

package mbssoc_int_req_pkg;
  localparam int unsigned INT_SEL_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2,
    S_GAP   = 2'd3
  } src_state_e;
endpackage

module mbssoc_int_req
  import mbssoc_int_req_pkg::*;
#(
  parameter int unsigned INT_W   = INT_SEL_WIDTH,
  parameter int unsigned CNT_W   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] evt_i,
  input  logic [INT_W-1:0] mask_i,
  input  logic [INT_W-1:0] int_ack_i,
  input  logic [INT_W-1:0] ovf_clr_i,
  output logic [INT_W-1:0] int_vec_o,
  output logic             pending_any_o,
  output logic [INT_W-1:0] overflow_o
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  src_state_e       state_q  [INT_W];
  src_state_e       state_d  [INT_W];
  logic [CNT_W-1:0] cnt_q    [INT_W];
  logic [CNT_W-1:0] cnt_d    [INT_W];
  logic [TMO_W-1:0] tmo_q    [INT_W];
  logic [TMO_W-1:0] tmo_d    [INT_W];
  // GAP was entered through a timeout, so leaving it must not consume a count
  logic [INT_W-1:0] gap_to_q;
  logic [INT_W-1:0] gap_to_d;

  logic [INT_W-1:0] int_vec_q;
  logic [INT_W-1:0] int_vec_d;
  logic             pend_q;
  logic             pend_d;
  logic [INT_W-1:0] overflow_q;
  logic [INT_W-1:0] overflow_d;

  logic [INT_W-1:0] evt_en_c;
  logic [INT_W-1:0] cnt_inc;
  logic [INT_W-1:0] cnt_dec;
  logic [INT_W-1:0] cnt_clr;
  logic [INT_W-1:0] ovf_set;

  // Qualified events: masked sources never see their pulses
  assign evt_en_c = evt_i & mask_i;

  // Per-source next-state, counter and output computation
  always_comb begin
    gap_to_d   = gap_to_q;
    cnt_inc    = '0;
    cnt_dec    = '0;
    cnt_clr    = '0;
    ovf_set    = '0;
    int_vec_d  = '0;
    pend_d     = 1'b0;
    overflow_d = overflow_q;
    for (int unsigned i = 0; i < INT_W; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tmo_d[i]   = tmo_q[i];

      // Any qualified event outside IDLE is queued, including one that
      // coincides with an ack transition
      cnt_inc[i] = evt_en_c[i] && (state_q[i] != S_IDLE);

      case (state_q[i])
        S_IDLE: begin
          if (evt_en_c[i]) begin
            state_d[i] = S_REQ;
            tmo_d[i]   = '0;
          end else if (mask_i[i] && (cnt_q[i] != '0)) begin
            state_d[i] = S_REQ;
            tmo_d[i]   = '0;
            cnt_dec[i] = 1'b1;
          end
        end
        S_REQ: begin
          tmo_d[i] = tmo_q[i] + TMO_W'(1);
          if (!mask_i[i]) begin
            state_d[i] = S_IDLE;
            cnt_clr[i] = 1'b1;
          end else if (int_ack_i[i]) begin
            state_d[i] = S_ACKED;
          end else if (tmo_q[i] == TMO_LAST) begin
            state_d[i]  = S_GAP;
            gap_to_d[i] = 1'b1;
          end
        end
        S_ACKED: begin
          if (!int_ack_i[i]) begin
            if (!mask_i[i]) begin
              state_d[i] = S_IDLE;
              cnt_clr[i] = 1'b1;
            end else if (cnt_q[i] != '0) begin
              state_d[i]  = S_GAP;
              gap_to_d[i] = 1'b0;
            end else begin
              state_d[i] = S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_to_d[i] = 1'b0;
          if (!mask_i[i]) begin
            state_d[i] = S_IDLE;
            cnt_clr[i] = 1'b1;
          end else begin
            state_d[i] = S_REQ;
            tmo_d[i]   = '0;
            cnt_dec[i] = !gap_to_q[i] && (cnt_q[i] != '0);
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase

      // Increment and decrement in the same cycle cancel out
      if (cnt_clr[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_inc[i] && !cnt_dec[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end

      int_vec_d[i] = (state_d[i] == S_REQ);
      pend_d       = pend_d | (state_d[i] != S_IDLE) | (cnt_d[i] != '0);
    end
    // A new loss in the same cycle as a clear keeps the flag set
    overflow_d = (overflow_q & ~ovf_clr_i) | ovf_set;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < INT_W; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        tmo_q[i]   <= '0;
      end
      gap_to_q   <= '0;
      int_vec_q  <= '0;
      pend_q     <= 1'b0;
      overflow_q <= '0;
    end else begin
      for (int unsigned i = 0; i < INT_W; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        tmo_q[i]   <= tmo_d[i];
      end
      gap_to_q   <= gap_to_d;
      int_vec_q  <= int_vec_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  assign int_vec_o     = int_vec_q;
  assign pending_any_o = pend_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_mbssoc_int_req.sv
// Directed bench for mbssoc_int_req: vector table plus multi-cycle sequences.

module tb_mbssoc_int_req;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] evt;
  logic [W-1:0] mask;
  logic [W-1:0] int_ack;
  logic [W-1:0] ovf_clr;
  logic [W-1:0] int_vec;
  logic         pending_any;
  logic [W-1:0] overflow;

  int n_checks = 0;
  int n_fail   = 0;

  mbssoc_int_req dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .evt_i         (evt),
    .mask_i        (mask),
    .int_ack_i     (int_ack),
    .ovf_clr_i     (ovf_clr),
    .int_vec_o     (int_vec),
    .pending_any_o (pending_any),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] evt;
    logic [W-1:0] mask;
    logic [W-1:0] ack;
    logic [W-1:0] clr;
    logic [W-1:0] exp_vec;
    logic         exp_pend;
    logic [W-1:0] exp_ovf;
    int           cnt_src;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic [W-1:0] e, input logic [W-1:0] m,
                     input logic [W-1:0] a, input logic [W-1:0] c, input logic [W-1:0] v,
                     input logic p, input logic [W-1:0] o, input int src, input int cnt);
    vec_t r;
    r.name = name; r.evt = e; r.mask = m; r.ack = a; r.clr = c;
    r.exp_vec = v; r.exp_pend = p; r.exp_ovf = o; r.cnt_src = src; r.exp_cnt = cnt;
    tbl.push_back(r);
  endtask

  function automatic logic [31:0] cnt_of(input int src);
    return 32'(dut.cnt_q[src]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hi;

    // Single event, ack five cycles later
    add("t1_evt",    8'h04, 8'hFF, 8'h00, 8'h00, 8'h04, 1'b1, 8'h00, 2, 0);
    for (int k = 0; k < 4; k++)
      add("t1_hold", 8'h00, 8'hFF, 8'h00, 8'h00, 8'h04, 1'b1, 8'h00, -1, 0);
    add("t1_ack",     8'h00, 8'hFF, 8'h04, 8'h00, 8'h00, 1'b1, 8'h00, -1, 0);
    add("t1_ackhold", 8'h00, 8'hFF, 8'h04, 8'h00, 8'h00, 1'b1, 8'h00, -1, 0);
    add("t1_ackdrop", 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2, 0);
    // Masking while REQ with two queued events
    add("t5_evt",    8'h10, 8'hFF, 8'h00, 8'h00, 8'h10, 1'b1, 8'h00, 4, 0);
    add("t5_q1",     8'h10, 8'hFF, 8'h00, 8'h00, 8'h10, 1'b1, 8'h00, 4, 1);
    add("t5_q2",     8'h10, 8'hFF, 8'h00, 8'h00, 8'h10, 1'b1, 8'h00, 4, 2);
    add("t5_mask",   8'h00, 8'hEF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4, 0);
    add("t5_mskevt", 8'h10, 8'hEF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4, 0);
    add("t5_unmask", 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4, 0);
    // Overflow: nine pulses saturate a 3-bit counter
    add("t3_evt0",   8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 1'b1, 8'h00, 1, 0);
    for (int p = 1; p <= 7; p++)
      add("t3_q",    8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 1'b1, 8'h00, 1, p);
    add("t3_sat",    8'h02, 8'hFF, 8'h00, 8'h00, 8'h02, 1'b1, 8'h02, 1, 7);
    add("t3_clr",    8'h00, 8'hFF, 8'h00, 8'h02, 8'h02, 1'b1, 8'h00, 1, 7);
    add("t3_setwin", 8'h02, 8'hFF, 8'h00, 8'h02, 8'h02, 1'b1, 8'h02, 1, 7);
    add("t3_mask",   8'h00, 8'hFD, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02, 1, 0);
    add("t3_idle",   8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h02, -1, 0);

    rst_n = 1'b0; evt = '0; mask = 8'hFF; int_ack = '0; ovf_clr = '0;
    #1;
    check("rst_vec", 32'(int_vec), 32'h0);
    check("rst_pend", 32'(pending_any), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    step(); step();
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      evt = tbl[k].evt; mask = tbl[k].mask; int_ack = tbl[k].ack; ovf_clr = tbl[k].clr;
      step();
      check({tbl[k].name, "_vec"}, 32'(int_vec), 32'(tbl[k].exp_vec));
      check({tbl[k].name, "_pend"}, 32'(pending_any), 32'(tbl[k].exp_pend));
      check({tbl[k].name, "_ovf"}, 32'(overflow), 32'(tbl[k].exp_ovf));
      if (tbl[k].cnt_src >= 0)
        check({tbl[k].name, "_cnt"}, cnt_of(tbl[k].cnt_src), 32'(tbl[k].exp_cnt));
    end
    evt = '0; mask = 8'hFF; int_ack = '0; ovf_clr = '0;

    // Queued events: one request plus three queued, four handshakes
    evt = 8'h01; step();
    check("t2_req", 32'(int_vec[0]), 32'h1);
    for (int k = 0; k < 3; k++) step();
    evt = '0;
    check("t2_cnt3", cnt_of(0), 32'd3);
    for (int k = 0; k < 4; k++) begin
      int_ack = 8'h01; step();
      check("t2_acklow", 32'(int_vec[0]), 32'h0);
      int_ack = 8'h00; step();
      check("t2_gaplow", 32'(int_vec[0]), 32'h0);
      if (k < 3) begin
        step();
        check("t2_rereq", 32'(int_vec[0]), 32'h1);
      end
    end
    step();
    check("t2_done_vec", 32'(int_vec[0]), 32'h0);
    check("t2_done_pend", 32'(pending_any), 32'h0);
    check("t2_ovf0", 32'(overflow[0]), 32'h0);

    // Timeout: 255 high cycles, one low, then high again
    evt = 8'h08; step(); evt = '0;
    hi = int'(int_vec[3]);
    while (hi < 300) begin
      step();
      if (!int_vec[3]) break;
      hi++;
    end
    check("t4_high_cycles", 32'(hi), 32'd255);
    check("t4_gap_low", 32'(int_vec[3]), 32'h0);
    step();
    check("t4_rearm", 32'(int_vec[3]), 32'h1);
    check("t4_cnt", cnt_of(3), 32'd0);
    int_ack = 8'h08; step();
    int_ack = 8'h00; step();
    check("t4_done_pend", 32'(pending_any), 32'h0);

    // Reset mid-request with queued events, then event and ack together
    evt = 8'h20; step(); step(); step(); evt = '0;
    check("t6_pre_cnt", cnt_of(5), 32'd2);
    check("t6_pre_ovf", 32'(overflow), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_vec", 32'(int_vec), 32'h0);
    check("t6_rst_pend", 32'(pending_any), 32'h0);
    check("t6_rst_ovf", 32'(overflow), 32'h0);
    check("t6_rst_cnt", cnt_of(5), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_idle_vec", 32'(int_vec), 32'h0);
    evt = 8'h20; step();
    check("t6_req", 32'(int_vec), 32'h20);
    evt = 8'h20; int_ack = 8'h20; step();
    check("t6_acked_vec", 32'(int_vec), 32'h0);
    check("t6_acked_cnt", cnt_of(5), 32'd1);
    evt = '0; int_ack = '0; step();
    check("t6_gap_vec", 32'(int_vec), 32'h0);
    check("t6_gap_pend", 32'(pending_any), 32'h1);
    step();
    check("t6_rereq", 32'(int_vec), 32'h20);
    check("t6_cnt0", cnt_of(5), 32'd0);
    int_ack = 8'h20; step();
    int_ack = 8'h00; step();
    check("t6_done_pend", 32'(pending_any), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
